data_mem_responder: RTL and testbench

- Data-memory responder serving the CPU's MEM-stage load/store port; it is the far end of that port.
- Reads are combinational, so data is returned in the same cycle the request is presented, as the MEM stage requires.
- Stores are posted into a small coalescing write buffer. The buffer drains into a single-port word array during idle bus cycles.
- Sits beside the instruction ROM in the top-level test harness and SoC wrapper.

---
 rtl/data_mem_responder_pkg.sv | 34 +++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_wbuf.sv | 120 ++++++++++++
 rtl/data_mem_responder.sv | 93 +++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared widths, buffer state type and byte-merge helper
// Purpose: constants and helpers shared by the data-memory responder and its write buffer.
// Contents: word/lane widths, write-buffer entry field widths, buffer state enum, merge_bytes().
package data_mem_responder_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_LANES  = 4;
   localparam int BYTE_W      = 8;

   // Write-buffer entry fields besides the word index: {valid, index, mask, data}
   localparam int ENT_MASK_W  = DMEM_LANES;
   localparam int ENT_DATA_W  = DMEM_DATA_W;

   typedef enum logic [1:0] {
      WB_EMPTY   = 2'd0,
      WB_PARTIAL = 2'd1,
      WB_FULL    = 2'd2
   } wbuf_state_t;

   // Byte-wise merge: lanes with mask set come from new_w, the rest from old_w.
   function automatic logic [DMEM_DATA_W-1:0] merge_bytes(
      input logic [DMEM_DATA_W-1:0] old_w,
      input logic [DMEM_DATA_W-1:0] new_w,
      input logic [ENT_MASK_W-1:0]  mask
   );
      logic [DMEM_DATA_W-1:0] res;
      for (int i = 0; i < DMEM_LANES; i++) begin
         res[i*BYTE_W +: BYTE_W] = mask[i] ? new_w[i*BYTE_W +: BYTE_W]
                                           : old_w[i*BYTE_W +: BYTE_W];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage load/store port between CPU and data memory
// Purpose: bundles the CPU data-memory request/response signals.
// Signals: mem_addr (byte address), mem_byte_slct (lane enables), data_to_write_mem,
//          mem_we, mem_re (requests), data_from_mem (combinational load data).
// Modports: master = CPU side, slave = memory responder side.
interface data_mem_responder_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       mem_addr;
   logic [3:0]        mem_byte_slct;
   logic [DATA_W-1:0] data_to_write_mem;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] data_from_mem;

   modport master (
      output mem_addr, mem_byte_slct, data_to_write_mem, mem_we, mem_re,
      input  data_from_mem
   );

   modport slave (
      input  mem_addr, mem_byte_slct, data_to_write_mem, mem_we, mem_re,
      output data_from_mem
   );
endinterface

// File: rtl/data_mem_responder_wbuf.sv
// rtl/data_mem_responder_wbuf.sv - coalescing FIFO write buffer (module dmem_wbuf)
// Purpose: holds posted stores, coalesces stores to a buffered word, drains oldest-first.
// Ports: clk, rst (async active-low); push_* (qualified store); drain_en (idle bus cycle);
//        lookup_idx -> lookup_mask/lookup_data (mask is 0 on miss); drain_* (head entry
//        written to the array when drain_fire); forced_drain; count; full.
module dmem_wbuf
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = 10,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   input  logic [IDX_W-1:0]      push_idx,
   input  logic [ENT_MASK_W-1:0] push_mask,
   input  logic [ENT_DATA_W-1:0] push_data,
   input  logic                  drain_en,
   input  logic [IDX_W-1:0]      lookup_idx,
   output logic [ENT_MASK_W-1:0] lookup_mask,
   output logic [ENT_DATA_W-1:0] lookup_data,
   output logic                  drain_fire,
   output logic [IDX_W-1:0]      drain_idx,
   output logic [ENT_MASK_W-1:0] drain_mask,
   output logic [ENT_DATA_W-1:0] drain_data,
   output logic                  forced_drain,
   output logic [CNT_W-1:0]      count,
   output logic                  full
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0]      valid_q;
   logic [IDX_W-1:0]      idx_q  [DEPTH];
   logic [ENT_MASK_W-1:0] mask_q [DEPTH];
   logic [ENT_DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]      head_q, tail_q, hit_ptr;
   logic [CNT_W-1:0]      count_q, count_d;
   wbuf_state_t           state_q, state_d;
   logic                  hit, coalesce, alloc, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // CAM: at most one valid entry per index, so the last match found is the only one.
   always_comb begin
      hit         = 1'b0;
      hit_ptr     = '0;
      lookup_mask = '0;
      lookup_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && idx_q[i] == push_idx) begin
            hit     = 1'b1;
            hit_ptr = PTR_W'(i);
         end
         if (valid_q[i] && idx_q[i] == lookup_idx) begin
            lookup_mask = mask_q[i];
            lookup_data = data_q[i];
         end
      end
   end

   assign coalesce     = push_valid && hit;
   assign alloc        = push_valid && !hit;
   assign forced_drain = alloc && (state_q == WB_FULL);
   assign pop          = forced_drain || (drain_en && state_q != WB_EMPTY);
   assign count_d      = count_q + CNT_W'(alloc) - CNT_W'(pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_EMPTY:   if (count_d != '0) state_d = WB_PARTIAL;
         WB_PARTIAL: begin
            if (count_d == CNT_W'(DEPTH)) state_d = WB_FULL;
            else if (count_d == '0)       state_d = WB_EMPTY;
         end
         WB_FULL:    if (count_d != CNT_W'(DEPTH)) state_d = WB_PARTIAL;
         default:    state_d = WB_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= WB_EMPTY;
      end else begin
         // On a forced drain head == tail; the push is ordered last so the slot stays valid.
         if (pop)   valid_q[head_q] <= 1'b0;
         if (alloc) valid_q[tail_q] <= 1'b1;
         if (pop)   head_q <= ptr_inc(head_q);
         if (alloc) tail_q <= ptr_inc(tail_q);
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (coalesce) begin
         data_q[hit_ptr] <= merge_bytes(data_q[hit_ptr], push_data, push_mask);
         mask_q[hit_ptr] <= mask_q[hit_ptr] | push_mask;
      end
      if (alloc) begin
         idx_q[tail_q]  <= push_idx;
         mask_q[tail_q] <= push_mask;
         data_q[tail_q] <= push_data;
      end
   end

   assign drain_fire = pop;
   assign drain_idx  = idx_q[head_q];
   assign drain_mask = mask_q[head_q];
   assign drain_data = data_q[head_q];
   assign count      = count_q;
   assign full       = (state_q == WB_FULL);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder for the CPU MEM-stage port
// Purpose: single-port word array with zero-latency loads and a posted, coalescing write buffer.
// Ports: clk, rst (async active-low); bus (data_mem_responder_if.slave); wbuf_count; wbuf_full;
//        addr_err (one-cycle pulse after an out-of-range access).
// Option: DMEM_PERF_EN adds saturating perf_loads, perf_stores, perf_forced_drains outputs.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int ADDR_W     = 10,
   parameter int WBUF_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   data_mem_responder_if.slave           bus,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
   output logic                          wbuf_full,
   output logic                          addr_err
`ifdef DMEM_PERF_EN
   ,
   output logic [31:0]                   perf_loads,
   output logic [31:0]                   perf_stores,
   output logic [31:0]                   perf_forced_drains
`endif
);
   logic [DATA_W-1:0]     mem_array [2**ADDR_W];
   logic                  in_range, push_valid, drain_en;
   logic [ADDR_W-1:0]     word_idx;
   logic [ENT_MASK_W-1:0] lk_mask, dr_mask;
   logic [ENT_DATA_W-1:0] lk_data, dr_data;
   logic                  dr_fire, forced;
   logic [ADDR_W-1:0]     dr_idx;
   logic                  unused_addr_lsbs;

   assign in_range         = (bus.mem_addr[31:ADDR_W+2] == '0);
   assign word_idx         = bus.mem_addr[ADDR_W+1:2];
   assign unused_addr_lsbs = ^bus.mem_addr[1:0];
   assign push_valid       = bus.mem_we && in_range && (bus.mem_byte_slct != '0);
   // The array port belongs to loads; a rejected store still counts as a busy cycle.
   assign drain_en         = !bus.mem_re && !bus.mem_we;

   dmem_wbuf #(
      .DEPTH (WBUF_DEPTH),
      .IDX_W (ADDR_W)
   ) u_wbuf (
      .clk          (clk),
      .rst          (rst),
      .push_valid   (push_valid),
      .push_idx     (word_idx),
      .push_mask    (bus.mem_byte_slct),
      .push_data    (bus.data_to_write_mem),
      .drain_en     (drain_en),
      .lookup_idx   (word_idx),
      .lookup_mask  (lk_mask),
      .lookup_data  (lk_data),
      .drain_fire   (dr_fire),
      .drain_idx    (dr_idx),
      .drain_mask   (dr_mask),
      .drain_data   (dr_data),
      .forced_drain (forced),
      .count        (wbuf_count),
      .full         (wbuf_full)
   );

   // Buffered bytes shadow the array; lookup reflects pre-edge state, so a same-cycle store is not seen.
   assign bus.data_from_mem = (bus.mem_re && in_range)
                              ? merge_bytes(mem_array[word_idx], lk_data, lk_mask)
                              : '0;

   always_ff @(posedge clk) begin
      if (dr_fire) mem_array[dr_idx] <= merge_bytes(mem_array[dr_idx], dr_data, dr_mask);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) addr_err <= 1'b0;
      else      addr_err <= (bus.mem_we || bus.mem_re) && !in_range;
   end

`ifdef DMEM_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_loads         <= '0;
         perf_stores        <= '0;
         perf_forced_drains <= '0;
      end else begin
         if (bus.mem_re && in_range && perf_loads != '1)  perf_loads  <= perf_loads + 32'd1;
         if (bus.mem_we && in_range && perf_stores != '1) perf_stores <= perf_stores + 32'd1;
         if (forced && perf_forced_drains != '1)          perf_forced_drains <= perf_forced_drains + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] wbuf_count;
   logic       wbuf_full;
   logic       addr_err;
`ifdef DMEM_PERF_EN
   logic [31:0] perf_loads, perf_stores, perf_forced_drains;
`endif

   int checks   = 0;
   int failures = 0;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .DATA_W     (32),
      .ADDR_W     (10),
      .WBUF_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .wbuf_count (wbuf_count),
      .wbuf_full  (wbuf_full),
      .addr_err   (addr_err)
`ifdef DMEM_PERF_EN
      ,
      .perf_loads         (perf_loads),
      .perf_stores        (perf_stores),
      .perf_forced_drains (perf_forced_drains)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      bit          re;
      logic [31:0] addr;
      logic [3:0]  slct;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_count;
      bit          exp_full;
      bit          exp_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit we, bit re, logic [31:0] addr, logic [3:0] slct,
                               logic [31:0] wdata, logic [31:0] exp_data,
                               int exp_count, bit exp_full, bit exp_err);
      vec_t v;
      v.we = we; v.re = re; v.addr = addr; v.slct = slct; v.wdata = wdata;
      v.exp_data = exp_data; v.exp_count = exp_count; v.exp_full = exp_full; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic drive(bit we, bit re, logic [31:0] addr, logic [3:0] slct, logic [31:0] wdata);
      bus.mem_we            = we;
      bus.mem_re            = re;
      bus.mem_addr          = addr;
      bus.mem_byte_slct     = slct;
      bus.data_to_write_mem = wdata;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Row of the status outputs, sampled mid-cycle before the next rising edge.
   task automatic check_status(string tag, logic [31:0] exp_data, int exp_count, bit exp_full, bit exp_err);
      check({tag, " data"},  bus.data_from_mem, exp_data);
      check({tag, " count"}, 32'(wbuf_count), 32'(exp_count));
      check({tag, " full"},  32'(wbuf_full), 32'(exp_full));
      check({tag, " err"},   32'(addr_err), 32'(exp_err));
   endtask

   task automatic step(bit we, bit re, logic [31:0] addr, logic [3:0] slct, logic [31:0] wdata);
      @(negedge clk);
      drive(we, re, addr, slct, wdata);
      #1;
   endtask

   initial begin
      //                 we re addr          slct  wdata         exp_data     cnt full err
      tbl.push_back(mk(1, 0, 32'h10,   4'hF, 32'h11223344, 32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h10,   4'h0, 32'h0,        32'h11223344, 1, 0, 0));
      tbl.push_back(mk(1, 0, 32'h20,   4'hF, 32'hAABBCCDD, 32'h0,        1, 0, 0));
      tbl.push_back(mk(1, 0, 32'h20,   4'h1, 32'h000000EE, 32'h0,        2, 0, 0));
      tbl.push_back(mk(0, 1, 32'h20,   4'h0, 32'h0,        32'hAABBCCEE, 2, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        2, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        1, 0, 0));
      tbl.push_back(mk(0, 1, 32'h20,   4'h0, 32'h0,        32'hAABBCCEE, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h10,   4'h0, 32'h0,        32'h11223344, 0, 0, 0));
      // fill the buffer, then a fifth miss forces the oldest out
      tbl.push_back(mk(1, 0, 32'h0,    4'hF, 32'hA0A0A0A0, 32'h0,        0, 0, 0));
      tbl.push_back(mk(1, 0, 32'h4,    4'hF, 32'hB1B1B1B1, 32'h0,        1, 0, 0));
      tbl.push_back(mk(1, 0, 32'h8,    4'hF, 32'hC2C2C2C2, 32'h0,        2, 0, 0));
      tbl.push_back(mk(1, 0, 32'hC,    4'hF, 32'hD3D3D3D3, 32'h0,        3, 0, 0));
      tbl.push_back(mk(1, 0, 32'h14,   4'hF, 32'hE5E5E5E5, 32'h0,        4, 1, 0));
      // load stream: count must hold while mem_re stays high
      tbl.push_back(mk(0, 1, 32'h0,    4'h0, 32'h0,        32'hA0A0A0A0, 4, 1, 0));
      tbl.push_back(mk(0, 1, 32'h4,    4'h0, 32'h0,        32'hB1B1B1B1, 4, 1, 0));
      tbl.push_back(mk(0, 1, 32'h14,   4'h0, 32'h0,        32'hE5E5E5E5, 4, 1, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        4, 1, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        3, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        2, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        1, 0, 0));
      tbl.push_back(mk(0, 1, 32'h0,    4'h0, 32'h0,        32'hA0A0A0A0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h4,    4'h0, 32'h0,        32'hB1B1B1B1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h8,    4'h0, 32'h0,        32'hC2C2C2C2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'hC,    4'h0, 32'h0,        32'hD3D3D3D3, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h14,   4'h0, 32'h0,        32'hE5E5E5E5, 0, 0, 0));
      // partial store merged over array data, then drained with its mask only
      tbl.push_back(mk(1, 0, 32'h4,    4'h6, 32'h00ABCD00, 32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h4,    4'h0, 32'h0,        32'hB1ABCDB1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        1, 0, 0));
      tbl.push_back(mk(0, 1, 32'h4,    4'h0, 32'h0,        32'hB1ABCDB1, 0, 0, 0));
      // out of range: 0x1000 would alias word 0 without the range check
      tbl.push_back(mk(0, 1, 32'h1000, 4'h0, 32'h0,        32'h0,        0, 0, 0));
      tbl.push_back(mk(1, 0, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 1, 32'h0,    4'h0, 32'h0,        32'hA0A0A0A0, 0, 0, 0));
      // empty byte select has no effect
      tbl.push_back(mk(1, 0, 32'h8,    4'h0, 32'hFFFFFFFF, 32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h8,    4'h0, 32'h0,        32'hC2C2C2C2, 0, 0, 0));
      // low address bits ignored: 0x13 is word 4 (0x10)
      tbl.push_back(mk(0, 1, 32'h13,   4'h0, 32'h0,        32'h11223344, 0, 0, 0));

      // reset state
      drive(0, 0, 32'h0, 4'h0, 32'h0);
      #1;
      check_status("reset", 32'h0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].slct, tbl[i].wdata);
         check_status($sformatf("row%0d", i), tbl[i].exp_data, tbl[i].exp_count,
                      tbl[i].exp_full, tbl[i].exp_err);
      end

      // store and load together: load sees pre-store data, store still lands
      step(1, 1, 32'hC, 4'hF, 32'h12345678);
      check_status("we_re", 32'hD3D3D3D3, 0, 0, 0);
      step(0, 1, 32'hC, 4'h0, 32'h0);
      check_status("we_re_after", 32'h12345678, 1, 0, 0);
      step(0, 0, 32'h0, 4'h0, 32'h0);
      check_status("we_re_idle", 32'h0, 1, 0, 0);
      step(0, 1, 32'hC, 4'h0, 32'h0);
      check_status("we_re_drained", 32'h12345678, 0, 0, 0);

      // asynchronous reset with three stores pending discards them
      step(1, 0, 32'h0, 4'hF, 32'h11111111);
      step(1, 0, 32'h4, 4'hF, 32'h22222222);
      step(1, 0, 32'h8, 4'hF, 32'h33333333);
      step(0, 0, 32'h0, 4'h0, 32'h0);
      check("rst_pre count", 32'(wbuf_count), 32'd3);
      #2 rst = 1'b0;
      #1;
      check("rst_async count", 32'(wbuf_count), 32'd0);
      check("rst_async full", 32'(wbuf_full), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(0, 1, 32'h0, 4'h0, 32'h0);
      check_status("rst_ld0", 32'hA0A0A0A0, 0, 0, 0);
      step(0, 1, 32'h4, 4'h0, 32'h0);
      check_status("rst_ld4", 32'hB1ABCDB1, 0, 0, 0);
      step(0, 1, 32'h8, 4'h0, 32'h0);
      check_status("rst_ld8", 32'hC2C2C2C2, 0, 0, 0);

      step(0, 0, 32'h0, 4'h0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
